// File: rtl/reset_seq.sv
// reset_seq: PLL-lock / button driven system reset sequencer.
// Synchronizes the PLL lock flag and the user button, debounces the button,
// and holds sys_rst until lock has been stable for LOCK_CYCLES followed by a
// further HOLD_CYCLES. Loss of lock or a debounced press re-asserts it.
//
//   state      | meaning
//   S_RESET    | just left async reset, one cycle before qualification starts
//   S_LOCKWAIT | counting consecutive cycles of stable lock with button idle
//   S_HOLD     | lock qualified, holding reset for the extra hold time
//   S_RUN      | reset released
module reset_seq #(
  parameter int SYNC_STAGES = 2,
  parameter int LOCK_CYCLES = 1024,
  parameter int HOLD_CYCLES = 16,
  parameter int DEBOUNCE    = 65536
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       locked,
  input  logic       btn,
  output logic       sys_rst,
  output logic       sys_rst_n,
  output logic [1:0] state
);

  localparam int MAXC = (LOCK_CYCLES > HOLD_CYCLES) ? LOCK_CYCLES : HOLD_CYCLES;
  localparam int CW   = (MAXC > 1) ? $clog2(MAXC) : 1;
  localparam int DW   = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;

  localparam logic [CW-1:0] LOCK_LAST = CW'(LOCK_CYCLES - 1);
  localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_CYCLES - 1);
  localparam logic [DW-1:0] DB_LAST   = DW'(DEBOUNCE - 1);

  if (LOCK_CYCLES < 1 || HOLD_CYCLES < 1 || SYNC_STAGES < 2 || DEBOUNCE < 1) begin : g_bad_params
    $error("reset_seq: illegal parameters (LOCK_CYCLES/HOLD_CYCLES/DEBOUNCE >= 1, SYNC_STAGES >= 2)");
  end

  typedef enum logic [1:0] {
    S_RESET    = 2'd0,
    S_LOCKWAIT = 2'd1,
    S_HOLD     = 2'd2,
    S_RUN      = 2'd3
  } state_t;

  logic [SYNC_STAGES-1:0] lock_sync;
  logic [SYNC_STAGES-1:0] btn_sync;
  logic                   lock_s;
  logic                   btn_s;
  logic                   btn_db;
  logic [DW-1:0]          dcnt;
  logic [CW-1:0]          cnt_q, cnt_d;
  state_t                 state_q, state_d;
  logic                   fault;

  assign lock_s = lock_sync[SYNC_STAGES-1];
  assign btn_s  = btn_sync[SYNC_STAGES-1];
  assign fault  = !lock_s || btn_db;
  assign state  = state_q;

  // Input synchronizers: the only logic that touches locked and btn.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lock_sync <= '0;
      btn_sync  <= '0;
    end else begin
      lock_sync <= {lock_sync[SYNC_STAGES-2:0], locked};
      btn_sync  <= {btn_sync[SYNC_STAGES-2:0], btn};
    end
  end

  // Button debounce: btn_db follows btn_s only after DEBOUNCE steady cycles.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dcnt   <= '0;
      btn_db <= 1'b0;
    end else if (btn_s == btn_db) begin
      dcnt <= '0;
    end else if (dcnt == DB_LAST) begin
      btn_db <= btn_s;
      dcnt   <= '0;
    end else begin
      dcnt <= dcnt + DW'(1);
    end
  end

  // FSM state, qualification counter and registered reset outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_RESET;
      cnt_q     <= '0;
      sys_rst   <= 1'b1;
      sys_rst_n <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      sys_rst   <= (state_d != S_RUN);
      sys_rst_n <= (state_d == S_RUN);
    end
  end

  // Next-state and counter logic; the counter is cleared on every transition.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_RESET: begin
        state_d = S_LOCKWAIT;
        cnt_d   = '0;
      end
      S_LOCKWAIT: begin
        if (fault) begin
          cnt_d = '0;
        end else if (cnt_q == LOCK_LAST) begin
          state_d = S_HOLD;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_HOLD: begin
        if (fault) begin
          state_d = S_LOCKWAIT;
          cnt_d   = '0;
        end else if (cnt_q == HOLD_LAST) begin
          state_d = S_RUN;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_RUN: begin
        if (fault) begin
          state_d = S_LOCKWAIT;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = S_RESET;
        cnt_d   = '0;
      end
    endcase
  end

endmodule
